vga_mode_sequencer: RTL and testbench

Controller that schedules display-mode changes for the VGA colour datapath and the seven-segment mode readout. It takes debounced button/switch levels and the VGA frame-start pulse, and queues manual "next mode" requests. Mode changes are applied only on frame boundaries, so a frame never tears mid-scan. It also provides a timed auto-cycle mode, and publishes the current mode index for the pattern generator and the segment driver.

---
 rtl/vga_mode_sequencer.sv | 70 +++++++
 tb/tb_vga_mode_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vga_mode_sequencer.sv
// Schedules display-mode advances (manual requests and timed auto-cycle) onto VGA frame boundaries.
// Latency: one cycle from i_Next/i_Auto edge or i_Frame_Start to outputs; all outputs registered.
module vga_mode_sequencer #(
    parameter int NUM_MODES   = 4,
    parameter int AUTO_FRAMES = 120
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Next,
    input  logic       i_Auto,
    input  logic       i_Frame_Start,
    output logic [3:0] o_Mode,
    output logic       o_Mode_Changed,
    output logic       o_Pending,
    output logic       o_Auto
);

    localparam logic [3:0]  LAST_MODE  = 4'(NUM_MODES - 1);
    localparam logic [11:0] LAST_FRAME = 12'(AUTO_FRAMES - 1);

    logic        prev_next;
    logic        prev_auto;
    logic [11:0] frame_cnt;

    logic       next_edge;
    logic       auto_edge;
    logic       apply_manual;
    logic       apply_auto;
    logic       do_advance;
    logic [3:0] advanced_mode;

    always_comb begin
        next_edge     = i_Next & ~prev_next;
        auto_edge     = i_Auto & ~prev_auto;
        // A queued request wins over the auto timer and applies in either mode.
        apply_manual  = i_Frame_Start & o_Pending;
        apply_auto    = i_Frame_Start & o_Auto & ~o_Pending & (frame_cnt == LAST_FRAME);
        do_advance    = apply_manual | apply_auto;
        advanced_mode = (o_Mode == LAST_MODE) ? 4'd0 : o_Mode + 4'd1;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            // prev regs reset high so a level held through reset is not seen as a press.
            prev_next      <= 1'b1;
            prev_auto      <= 1'b1;
            frame_cnt      <= 12'd0;
            o_Mode         <= 4'd0;
            o_Mode_Changed <= 1'b0;
            o_Pending      <= 1'b0;
            o_Auto         <= 1'b0;
        end else begin
            prev_next      <= i_Next;
            prev_auto      <= i_Auto;
            o_Mode_Changed <= do_advance;
            if (do_advance) begin
                o_Mode <= advanced_mode;
            end
            // A fresh edge re-queues even when the old request is consumed this cycle.
            o_Pending <= next_edge | (o_Pending & ~i_Frame_Start);
            if (auto_edge) begin
                o_Auto    <= ~o_Auto;
                frame_cnt <= 12'd0;
            end else if (i_Frame_Start && o_Auto) begin
                frame_cnt <= do_advance ? 12'd0 : frame_cnt + 12'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Directed bench for vga_mode_sequencer (NUM_MODES=4, AUTO_FRAMES=3): vector table plus auto/reset sequences.
module tb_vga_mode_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       nxt;
    logic       aut;
    logic       fs;
    logic [3:0] mode;
    logic       changed;
    logic       pending;
    logic       auto_on;

    int n_cmp = 0;
    int n_bad = 0;

    vga_mode_sequencer #(.NUM_MODES(4), .AUTO_FRAMES(3)) dut (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_Next        (nxt),
        .i_Auto        (aut),
        .i_Frame_Start (fs),
        .o_Mode        (mode),
        .o_Mode_Changed(changed),
        .o_Pending     (pending),
        .o_Auto        (auto_on)
    );

    always #5 clk = ~clk;

    // in = {rst, nxt, aut, fs}; flags = {changed, pending, auto}; outputs are those after the edge.
    typedef struct packed {
        logic [3:0] in;
        logic [3:0] mode;
        logic [2:0] flags;
    } vec_t;

    vec_t tbl[64];
    int   nv = 0;

    task automatic add(input logic [3:0] in, input logic [3:0] m, input logic [2:0] fl);
        tbl[nv] = '{in, m, fl};
        nv++;
    endtask

    // Drive inputs at a falling edge, let one rising edge pass, return at the next falling edge.
    task automatic cyc(input logic [3:0] in);
        {rst, nxt, aut, fs} = in;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [3:0] m, input logic [2:0] fl);
        n_cmp++;
        if ({mode, changed, pending, auto_on} !== {m, fl}) begin
            n_bad++;
            $display("FAIL %s: got mode=%0d chg=%b pend=%b auto=%b, want mode=%0d chg=%b pend=%b auto=%b",
                     name, mode, changed, pending, auto_on, m, fl[2], fl[1], fl[0]);
        end
    endtask

    // One frame start followed by an idle cycle; checks outputs right after the frame start.
    task automatic frame(input string name, input logic aut_lvl, input logic [3:0] m, input logic [2:0] fl);
        cyc({1'b0, 1'b0, aut_lvl, 1'b1});
        chk(name, m, fl);
        cyc({1'b0, 1'b0, aut_lvl, 1'b0});
    endtask

    initial begin
        {rst, nxt, aut, fs} = 4'b1000;

        // Reset, press, frame start; then coalescing, idle frame, wrap and coincidence cases.
        add(4'b1000, 4'd0, 3'b000);
        add(4'b0000, 4'd0, 3'b000);
        add(4'b0100, 4'd0, 3'b010);
        add(4'b0100, 4'd0, 3'b010);
        add(4'b0000, 4'd0, 3'b010);
        add(4'b0000, 4'd0, 3'b010);
        add(4'b0000, 4'd0, 3'b010);
        add(4'b0001, 4'd1, 3'b100);
        add(4'b0000, 4'd1, 3'b000);
        add(4'b0100, 4'd1, 3'b010);
        add(4'b0000, 4'd1, 3'b010);
        add(4'b0100, 4'd1, 3'b010);
        add(4'b0000, 4'd1, 3'b010);
        add(4'b0100, 4'd1, 3'b010);
        add(4'b0000, 4'd1, 3'b010);
        add(4'b0001, 4'd2, 3'b100);
        add(4'b0000, 4'd2, 3'b000);
        add(4'b0001, 4'd2, 3'b000);
        add(4'b0100, 4'd2, 3'b010);
        add(4'b0001, 4'd3, 3'b100);
        add(4'b0100, 4'd3, 3'b010);
        add(4'b0001, 4'd0, 3'b100);
        add(4'b0101, 4'd0, 3'b010);
        add(4'b0001, 4'd1, 3'b100);
        add(4'b0100, 4'd1, 3'b010);
        add(4'b0000, 4'd1, 3'b010);
        add(4'b0101, 4'd2, 3'b110);
        add(4'b0000, 4'd2, 3'b010);
        add(4'b0001, 4'd3, 3'b100);
        add(4'b0000, 4'd3, 3'b000);

        for (int i = 0; i < nv; i++) begin
            cyc(tbl[i].in);
            chk($sformatf("vec%0d", i), tbl[i].mode, tbl[i].flags);
        end

        // Auto-cycle period: advances on frame starts 3, 6 and 9.
        cyc(4'b1000);
        cyc(4'b0000);
        cyc(4'b0010);
        chk("auto_on", 4'd0, 3'b001);
        cyc(4'b0000);
        frame("auto_f1", 1'b0, 4'd0, 3'b001);
        frame("auto_f2", 1'b0, 4'd0, 3'b001);
        frame("auto_f3", 1'b0, 4'd1, 3'b101);
        frame("auto_f4", 1'b0, 4'd1, 3'b001);
        frame("auto_f5", 1'b0, 4'd1, 3'b001);
        frame("auto_f6", 1'b0, 4'd2, 3'b101);
        frame("auto_f7", 1'b0, 4'd2, 3'b001);
        frame("auto_f8", 1'b0, 4'd2, 3'b001);
        frame("auto_f9", 1'b0, 4'd3, 3'b101);

        // Manual request in auto mode restarts the frame count.
        frame("amix_f1", 1'b0, 4'd3, 3'b001);
        cyc(4'b0100);
        chk("amix_req", 4'd3, 3'b011);
        cyc(4'b0000);
        frame("amix_f2", 1'b0, 4'd0, 3'b101);
        frame("amix_f3", 1'b0, 4'd0, 3'b001);
        frame("amix_f4", 1'b0, 4'd0, 3'b001);
        frame("amix_f5", 1'b0, 4'd1, 3'b101);

        // Auto toggle coincident with the due frame start: old mode applies, then auto turns off.
        frame("acoin_f1", 1'b0, 4'd1, 3'b001);
        frame("acoin_f2", 1'b0, 4'd1, 3'b001);
        cyc(4'b0011);
        chk("acoin_f3", 4'd2, 3'b100);
        cyc(4'b0000);
        frame("acoin_f4", 1'b0, 4'd2, 3'b000);

        // Reset with pending, auto on, counter at 2.
        cyc(4'b0010);
        chk("rst_auto_on", 4'd2, 3'b001);
        cyc(4'b0000);
        frame("rst_f1", 1'b0, 4'd2, 3'b001);
        frame("rst_f2", 1'b0, 4'd2, 3'b001);
        cyc(4'b0100);
        chk("rst_req", 4'd2, 3'b011);
        cyc(4'b1000);
        chk("rst_clear", 4'd0, 3'b000);

        // Counter must have been cleared: re-enable auto, advance only on third frame start.
        cyc(4'b0000);
        cyc(4'b0010);
        cyc(4'b0000);
        frame("rcnt_f1", 1'b0, 4'd0, 3'b001);
        frame("rcnt_f2", 1'b0, 4'd0, 3'b001);
        frame("rcnt_f3", 1'b0, 4'd1, 3'b101);

        // Levels held high across reset release produce no edge until re-pressed.
        cyc(4'b1110);
        chk("hold_rst", 4'd0, 3'b000);
        cyc(4'b0110);
        chk("hold_rel1", 4'd0, 3'b000);
        cyc(4'b0110);
        chk("hold_rel2", 4'd0, 3'b000);
        cyc(4'b0000);
        chk("hold_low", 4'd0, 3'b000);
        cyc(4'b0110);
        chk("hold_repress", 4'd0, 3'b011);
        cyc(4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
